// File: rtl/mem_map_pkg.sv
// Address map and STATUS bit layout for the CPU data-side bus target.
package mem_map_pkg;
    localparam logic [31:0] MMIO_BASE    = 32'hFFFF_0000;

    localparam logic [15:0] OFF_TX_DATA  = 16'h0000;
    localparam logic [15:0] OFF_STATUS   = 16'h0004;
    localparam logic [15:0] OFF_CYCLE_LO = 16'h0008;
    localparam logic [15:0] OFF_CYCLE_HI = 16'h000C;
    localparam logic [15:0] OFF_TOHOST   = 16'h0010;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;

    function automatic logic [31:0] status_word(input logic ovf, input logic full, input logic empty);
        logic [31:0] w;
        w           = '0;
        w[ST_EMPTY] = empty;
        w[ST_FULL]  = full;
        w[ST_OVF]   = ovf;
        return w;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head reads as zero while empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr;
    logic [AW:0]      r_rd;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    assign w_empty = (r_wr == r_rd);
    assign w_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_pop   = i_pop && !w_empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_push  = i_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr[AW-1:0]] <= i_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_head  = w_empty ? '0 : r_mem[r_rd[AW-1:0]];
endmodule

// File: rtl/data_bus_mmio.sv
// CPU data-side target: byte-lane word RAM plus an MMIO page with TX FIFO,
// 64-bit cycle counter and tohost halt register.
module data_bus_mmio #(
    parameter int          RAM_WORDS  = 16384,
    parameter logic [31:0] MMIO_BASE  = mem_map_pkg::MMIO_BASE,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_read,
    input  logic [3:0]  data_write,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        halt,
    output logic [31:0] halt_code
);
    import mem_map_pkg::*;

    localparam int AW = $clog2(RAM_WORDS);

    logic [31:0]   r_ram [RAM_WORDS];
    logic [31:0]   r_data_out;
    logic [63:0]   r_cycle;
    logic [31:0]   r_hi_snap;
    logic          r_ovf;
    logic          r_halt;
    logic [31:0]   r_halt_code;

    logic          w_is_mmio;
    logic [15:0]   w_off;
    logic [AW-1:0] w_idx;
    logic          w_wr_any;
    logic          w_push_req;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [7:0]    w_head;
    logic          w_ovf_set;
    logic          w_ovf_clr;
    logic [31:0]   w_mmio_rdata;

    assign w_is_mmio  = (data_addr[31:16] == MMIO_BASE[31:16]);
    assign w_off      = data_addr[15:0] & 16'hFFFC;
    assign w_idx      = data_addr[AW+1:2];
    assign w_wr_any   = |data_write;

    assign w_push_req = w_is_mmio && (w_off == OFF_TX_DATA) && data_write[0];
    assign w_pop      = tx_ready && !w_empty;
    assign w_ovf_set  = w_push_req && w_full && !w_pop;
    assign w_ovf_clr  = w_is_mmio && (w_off == OFF_STATUS) && data_write[0] && data_in[ST_OVF];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push_req),
        .i_pop   (tx_ready),
        .i_data  (data_in[7:0]),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    always_comb begin
        w_mmio_rdata = '0;
        case (w_off)
            OFF_STATUS:   w_mmio_rdata = status_word(r_ovf, w_full, w_empty);
            OFF_CYCLE_LO: w_mmio_rdata = r_cycle[31:0];
            OFF_CYCLE_HI: w_mmio_rdata = r_hi_snap;
            OFF_TOHOST:   w_mmio_rdata = r_halt_code;
            default:      w_mmio_rdata = '0;
        endcase
    end

    // RAM is not reset; the read below sees the pre-write word on a same-cycle collision.
    always_ff @(posedge clk) begin
        if (!w_is_mmio) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (data_write[lane])
                    r_ram[w_idx][8*lane +: 8] <= data_in[8*lane +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_out <= '0;
            r_hi_snap  <= '0;
        end else if (data_read) begin
            r_data_out <= w_is_mmio ? w_mmio_rdata : r_ram[w_idx];
            if (w_is_mmio && (w_off == OFF_CYCLE_LO))
                r_hi_snap <= r_cycle[63:32];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle     <= '0;
            r_ovf       <= 1'b0;
            r_halt      <= 1'b0;
            r_halt_code <= '0;
        end else begin
            r_cycle <= r_cycle + 64'd1;
            if (w_ovf_set)
                r_ovf <= 1'b1;
            else if (w_ovf_clr)
                r_ovf <= 1'b0;
            if (w_is_mmio && (w_off == OFF_TOHOST) && w_wr_any) begin
                r_halt      <= 1'b1;
                r_halt_code <= data_in;
            end
        end
    end

    assign data_out  = r_data_out;
    assign tx_valid  = !w_empty;
    assign tx_data   = w_head;
    assign halt      = r_halt;
    assign halt_code = r_halt_code;
endmodule

// File: tb/tb_data_bus_mmio.sv
// Directed checks of RAM, TX FIFO, cycle counter and tohost against hand-computed values.
module tb_data_bus_mmio;
    localparam logic [31:0] MB = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_read;
    logic [3:0]  data_write;
    logic [31:0] data_addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        halt;
    logic [31:0] halt_code;

    int n_cmp = 0;
    int n_err = 0;

    data_bus_mmio dut (
        .clk        (clk),
        .rst        (rst),
        .data_read  (data_read),
        .data_write (data_write),
        .data_addr  (data_addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .halt       (halt),
        .halt_code  (halt_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Each bus task starts and ends at a negedge with the bus idle.
    task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        data_addr = a; data_write = be; data_in = d;
        @(negedge clk);
        data_write = 4'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        data_addr = a; data_read = 1'b1;
        @(negedge clk);
        data_read = 1'b0;
    endtask

    initial begin
        rst = 1'b1; data_read = 1'b0; data_write = 4'b0; data_addr = '0; data_in = '0; tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_data_out", data_out, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_halt", halt, 0);
        chk("rst_halt_code", halt_code, 0);
        rst = 1'b0;

        // RAM word write / read latency / hold
        wr(32'h100, 4'hF, 32'hDEADBEEF);
        rd(32'h100);
        chk("ram_rd", data_out, 32'hDEADBEEF);
        data_addr = 32'h0;
        @(negedge clk);
        chk("ram_hold", data_out, 32'hDEADBEEF);

        // Byte lane write
        wr(32'h100, 4'hF, 32'h11223344);
        wr(32'h102, 4'b0100, 32'h5A5A5A5A);
        rd(32'h100);
        chk("ram_sb", data_out, 32'h115A3344);

        // Read+write collision returns pre-write word
        data_addr = 32'h100; data_read = 1'b1; data_write = 4'hF; data_in = 32'hCAFEF00D;
        @(negedge clk);
        data_read = 1'b0; data_write = 4'b0;
        chk("rw_collide", data_out, 32'h115A3344);
        rd(32'h100);
        chk("rw_after", data_out, 32'hCAFEF00D);

        // Address wrap: 0x10100 aliases 0x100; MMIO writes never touch RAM
        rd(32'h0001_0100);
        chk("ram_wrap", data_out, 32'hCAFEF00D);
        wr(MB + 32'h100, 4'hF, 32'hFFFFFFFF);
        rd(32'h100);
        chk("mmio_no_ram", data_out, 32'hCAFEF00D);
        rd(MB + 32'h100);
        chk("mmio_other_rd", data_out, 0);

        // Fill FIFO past full with consumer stalled
        for (int i = 1; i <= 9; i++) wr(MB, 4'b0001, {24'h0, 8'(i)});
        rd(MB + 32'h4);
        chk("st_full_ovf", data_out, 32'b110);
        rd(MB);
        chk("tx_data_rd0", data_out, 0);
        tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("drain_v%0d", i), tx_valid, 1);
            chk($sformatf("drain_d%0d", i), tx_data, 8'(i));
            @(negedge clk);
        end
        tx_ready = 1'b0;
        chk("drain_empty", tx_valid, 0);
        rd(MB + 32'h4);
        chk("st_empty_ovf", data_out, 32'b101);
        wr(MB + 32'h4, 4'b0001, 32'h4);
        rd(MB + 32'h4);
        chk("st_w1c", data_out, 32'b001);

        // Push into full FIFO while popping
        for (int i = 1; i <= 8; i++) wr(MB, 4'b0001, {24'h0, 8'(i)});
        rd(MB + 32'h4);
        chk("st_full", data_out, 32'b010);
        tx_ready = 1'b1;
        chk("fullpp_head", tx_data, 8'h01);
        wr(MB, 4'b0001, 32'hAA);
        tx_ready = 1'b0;
        rd(MB + 32'h4);
        chk("st_fullpp", data_out, 32'b010);
        tx_ready = 1'b1;
        for (int i = 2; i <= 9; i++) begin
            chk($sformatf("pp_d%0d", i), tx_data, (i == 9) ? 8'hAA : 8'(i));
            @(negedge clk);
        end
        chk("pp_empty", tx_valid, 0);

        // Push+pop on empty: push lands, no bypass
        wr(MB, 4'b0001, 32'h77);
        chk("emptypp_v", tx_valid, 1);
        chk("emptypp_d", tx_data, 8'h77);
        @(negedge clk);
        chk("emptypp_pop", tx_valid, 0);
        tx_ready = 1'b0;

        // Coherent 64-bit counter read across the 32-bit wrap
        force dut.r_cycle = 64'h0000_0000_FFFF_FFFF;
        rd(MB + 32'h8);
        release dut.r_cycle;
        chk("cyc_lo", data_out, 32'hFFFFFFFF);
        rd(MB + 32'hC);
        chk("cyc_hi_snap", data_out, 0);
        rd(MB + 32'h8);
        chk("cyc_lo2_small", (data_out < 32'd16), 1);
        rd(MB + 32'hC);
        chk("cyc_hi2", data_out, 1);

        // tohost halt, then reset mid-read with a byte queued
        wr(MB, 4'b0001, 32'h33);
        wr(MB + 32'h10, 4'hF, 32'h1);
        chk("halt", halt, 1);
        chk("halt_code", halt_code, 1);
        rd(MB + 32'h10);
        chk("tohost_rd", data_out, 1);
        data_addr = 32'h100; data_read = 1'b1; rst = 1'b1;
        repeat (2) @(negedge clk);
        data_read = 1'b0;
        chk("rst2_data_out", data_out, 0);
        chk("rst2_tx_valid", tx_valid, 0);
        chk("rst2_tx_data", tx_data, 0);
        chk("rst2_halt", halt, 0);
        chk("rst2_halt_code", halt_code, 0);
        rst = 1'b0;
        rd(MB + 32'h8);
        chk("cyc_restart", data_out, 0);
        rd(MB + 32'hC);
        chk("cyc_restart_hi", data_out, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
